// File: rtl/bip_debug_sequencer.sv
// Run/step/halt sequencer for the accumulator processor.
// Accepts run/step command bytes from the UART receiver, gates CPU execution
// with a clock-enable, stops on the halt opcode, counts executed cycles and
// returns a 6-byte status frame (PC, ACC, cycle count; low byte first) to the
// UART transmitter over a start/done handshake.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   rx_data, rx_done  received command byte and its one-cycle strobe
//   tx_done           transmitter finished the current byte
//   OpCode, pc, acc   opcode at PC, program counter, accumulator from the CPU
//   cpu_en            CPU clock-enable
//   tx_start, tx_data transmit request strobe and byte
//   halted            sticky halt flag, cleared only by rst
module bip_debug_sequencer #(
  parameter int unsigned AB       = 11,
  parameter int unsigned DB       = 16,
  parameter int unsigned CW       = 16,
  parameter logic [4:0]  HALT_OP  = 5'b00000,
  parameter logic [7:0]  CMD_RUN  = 8'h63,
  parameter logic [7:0]  CMD_STEP = 8'h73
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_done,
  input  logic          tx_done,
  input  logic [4:0]    OpCode,
  input  logic [AB-1:0] pc,
  input  logic [DB-1:0] acc,
  output logic          cpu_en,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  output logic          halted
);

  typedef enum logic [2:0] {StIdle, StRun, StStep, StSend, StWaitTx} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          halted_q, halted_d;
  logic [15:0]   pc_snap_q, pc_snap_d;
  logic [15:0]   acc_snap_q, acc_snap_d;
  logic [15:0]   cnt_snap_q, cnt_snap_d;
  logic [7:0]    tx_data_q, tx_data_d;

  logic        is_halt;
  logic        first_send;
  logic [15:0] pc_src, acc_src, cnt_src;
  logic [7:0]  cur_byte;

  assign is_halt = (OpCode == HALT_OP);
  assign cpu_en  = ((state_q == StRun) || (state_q == StStep)) && !is_halt;

  // The CPU is frozen from SEND onward, so during the first SEND cycle the live
  // pc/acc/counter already hold the post-step values (an enabled final cycle has
  // landed). Byte 0 is sent from the live values and the shadow registers are
  // loaded in the same cycle; later bytes come from the shadows.
  assign first_send = (state_q == StSend) && (idx_q == 3'd0);
  assign pc_src     = first_send ? 16'(pc)    : pc_snap_q;
  assign acc_src    = first_send ? 16'(acc)   : acc_snap_q;
  assign cnt_src    = first_send ? 16'(cnt_q) : cnt_snap_q;

  always_comb begin
    cur_byte = 8'h00;
    case (idx_q)
      3'd0:    cur_byte = pc_src[7:0];
      3'd1:    cur_byte = pc_src[15:8];
      3'd2:    cur_byte = acc_src[7:0];
      3'd3:    cur_byte = acc_src[15:8];
      3'd4:    cur_byte = cnt_src[7:0];
      3'd5:    cur_byte = cnt_src[15:8];
      default: cur_byte = 8'h00;
    endcase
  end

  assign tx_start = (state_q == StSend);
  assign tx_data  = (state_q == StSend) ? cur_byte : tx_data_q;
  assign halted   = halted_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    halted_d   = halted_q;
    pc_snap_d  = pc_snap_q;
    acc_snap_d = acc_snap_q;
    cnt_snap_d = cnt_snap_q;
    tx_data_d  = tx_data_q;
    // Saturating executed-cycle counter.
    cnt_d      = (cpu_en && (cnt_q != {CW{1'b1}})) ? cnt_q + 1'b1 : cnt_q;

    unique case (state_q)
      StIdle: begin
        if (rx_done) begin
          if (rx_data == CMD_RUN) begin
            state_d = StRun;
          end else if (rx_data == CMD_STEP) begin
            state_d = StStep;
          end
        end
      end
      StRun: begin
        if (is_halt) begin
          halted_d = 1'b1;
          state_d  = StSend;
        end
      end
      StStep: begin
        if (is_halt) begin
          halted_d = 1'b1;
        end
        state_d = StSend;
      end
      StSend: begin
        if (first_send) begin
          pc_snap_d  = pc_src;
          acc_snap_d = acc_src;
          cnt_snap_d = cnt_src;
        end
        tx_data_d = cur_byte;
        state_d   = StWaitTx;
      end
      StWaitTx: begin
        // rx_done is ignored here, including when it coincides with tx_done.
        if (tx_done) begin
          if (idx_q == 3'd5) begin
            idx_d   = 3'd0;
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = StSend;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= 3'd0;
      halted_q   <= 1'b0;
      pc_snap_q  <= 16'h0000;
      acc_snap_q <= 16'h0000;
      cnt_snap_q <= 16'h0000;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      halted_q   <= halted_d;
      pc_snap_q  <= pc_snap_d;
      acc_snap_q <= acc_snap_d;
      cnt_snap_q <= cnt_snap_d;
      tx_data_q  <= tx_data_d;
    end
  end

endmodule

// File: tb/tb_bip_debug_sequencer.sv
// Directed testbench for bip_debug_sequencer. A tiny CPU model advances PC by 1
// and ACC by 3 on each enabled cycle and presents the halt opcode at halt_addr.
// A second instance with a 2-bit counter shares all stimulus to exercise
// counter saturation.
module tb_bip_debug_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic        tx_done = 1'b0;
  logic [4:0]  opcode;
  logic [10:0] pc_m;
  logic [15:0] acc_m;
  logic [10:0] halt_addr = 11'd4;

  logic        cpu_en, tx_start, halted;
  logic [7:0]  tx_data;
  logic        cpu_en2, tx_start2, halted2;
  logic [7:0]  tx_data2;

  int n_cmp = 0;
  int n_err = 0;
  int en_cnt = 0;
  int en2_cnt = 0;
  int ts_cnt = 0;

  logic [7:0] frm[6];
  logic [7:0] frm2[6];

  always #5 clk = ~clk;

  bip_debug_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .tx_done  (tx_done),
    .OpCode   (opcode),
    .pc       (pc_m),
    .acc      (acc_m),
    .cpu_en   (cpu_en),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .halted   (halted)
  );

  bip_debug_sequencer #(.CW(2)) dut_sat (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .tx_done  (tx_done),
    .OpCode   (opcode),
    .pc       (pc_m),
    .acc      (acc_m),
    .cpu_en   (cpu_en2),
    .tx_start (tx_start2),
    .tx_data  (tx_data2),
    .halted   (halted2)
  );

  // CPU model
  assign opcode = (pc_m == halt_addr) ? 5'd0 : 5'd1;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_m  <= 11'd0;
      acc_m <= 16'd0;
    end else if (cpu_en) begin
      pc_m  <= pc_m + 11'd1;
      acc_m <= acc_m + 16'd3;
    end
  end

  always @(negedge clk) begin
    if (cpu_en)   en_cnt++;
    if (cpu_en2)  en2_cnt++;
    if (tx_start) ts_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (tx_start) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Collect nbytes of a frame; with inject, rx_done pulses during and with tx_done.
  task automatic get_frame(input int nbytes, input bit inject);
    bit ok;
    logic [7:0] held;
    for (int i = 0; i < nbytes; i++) begin
      wait_start(ok);
      if (!ok) begin
        check_eq("tx_start timeout", 32'(ok), 32'd1);
        return;
      end
      frm[i]  = tx_data;
      frm2[i] = tx_data2;
      held    = tx_data;
      @(negedge clk);
      check_eq($sformatf("tx_start pulse b%0d", i), 32'(tx_start), 32'd0);
      if (inject) send_rx(8'h73);
      tick(2);
      check_eq($sformatf("tx_data hold b%0d", i), 32'(tx_data), 32'(held));
      if (inject) begin
        rx_data = 8'h63;
        rx_done = 1'b1;
      end
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      rx_done = 1'b0;
    end
  endtask

  // exp byte i lives at exp[8*i +: 8]
  task automatic check_frame(input string tag, input logic [47:0] exp);
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("%s byte%0d", tag, i), 32'(frm[i]), 32'(exp[8*i +: 8]));
    end
  endtask

  initial begin
    int e0, e20, t0;
    bit ok;
    logic [7:0] held;

    // Reset state
    #1;
    check_eq("rst cpu_en", 32'(cpu_en), 32'd0);
    check_eq("rst tx_start", 32'(tx_start), 32'd0);
    check_eq("rst tx_data", 32'(tx_data), 32'd0);
    check_eq("rst halted", 32'(halted), 32'd0);
    tick(3);
    rst = 1'b0;
    tick(2);

    // Run to HLT at address 4
    e0 = en_cnt; e20 = en2_cnt;
    send_rx(8'h63);
    get_frame(6, 1'b0);
    check_eq("run cpu_en cycles", 32'(en_cnt - e0), 32'd4);
    check_eq("run halted", 32'(halted), 32'd1);
    check_frame("run", {8'h00, 8'h04, 8'h00, 8'h0C, 8'h00, 8'h04});
    check_eq("sat cpu_en cycles", 32'(en2_cnt - e20), 32'd4);
    check_eq("sat cnt lo", 32'(frm2[4]), 32'h03);
    check_eq("sat cnt hi", 32'(frm2[5]), 32'h00);

    // Step on halted CPU
    e0 = en_cnt;
    send_rx(8'h73);
    get_frame(6, 1'b0);
    check_eq("halted step cycles", 32'(en_cnt - e0), 32'd0);
    check_eq("halted step halted", 32'(halted), 32'd1);
    check_frame("hstep", {8'h00, 8'h04, 8'h00, 8'h0C, 8'h00, 8'h04});
    check_eq("sat hold cnt", 32'(frm2[4]), 32'h03);
    check_eq("sat halted", 32'(halted2), 32'd1);

    // Unknown command ignored
    e0 = en_cnt; t0 = ts_cnt;
    send_rx(8'h41);
    tick(6);
    check_eq("bad cmd cpu_en", 32'(en_cnt - e0), 32'd0);
    check_eq("bad cmd tx_start", 32'(ts_cnt - t0), 32'd0);

    // Stall in WAIT_TX on byte index 2, then reset mid-frame
    send_rx(8'h73);
    get_frame(2, 1'b0);
    wait_start(ok);
    check_eq("stall start seen", 32'(ok), 32'd1);
    held = tx_data;
    check_eq("stall byte", 32'(held), 32'h0C);
    @(negedge clk);
    t0 = ts_cnt;
    tick(25);
    check_eq("stall tx_data mid", 32'(tx_data), 32'(held));
    tick(25);
    check_eq("stall no tx_start", 32'(ts_cnt - t0), 32'd0);
    check_eq("stall tx_data end", 32'(tx_data), 32'(held));
    #2 rst = 1'b1;
    #1;
    check_eq("mid rst tx_data", 32'(tx_data), 32'd0);
    check_eq("mid rst tx_start", 32'(tx_start), 32'd0);
    check_eq("mid rst cpu_en", 32'(cpu_en), 32'd0);
    check_eq("mid rst halted", 32'(halted), 32'd0);
    tick(2);
    rst = 1'b0;
    t0 = ts_cnt;
    tick(5);
    check_eq("post rst no tx_start", 32'(ts_cnt - t0), 32'd0);

    // Step from reset, rx_done noise during WAIT_TX
    e0 = en_cnt;
    send_rx(8'h73);
    get_frame(6, 1'b1);
    check_frame("step", {8'h00, 8'h01, 8'h00, 8'h03, 8'h00, 8'h01});
    check_eq("step cpu_en cycles", 32'(en_cnt - e0), 32'd1);
    check_eq("step halted", 32'(halted), 32'd0);
    t0 = ts_cnt;
    tick(10);
    check_eq("idle no tx_start", 32'(ts_cnt - t0), 32'd0);
    check_eq("idle no cpu_en", 32'(en_cnt - e0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
